// File: rtl/fitness_pkg.sv
// Shared constants and small helpers for the fitness front-end blocks.
package fitness_pkg;

    localparam int STEP_SAT = 7;    // steps_per_second ceiling (3-bit output)
    localparam int CNT_SAT  = 15;   // per-frame event counter ceiling
    localparam int HR_MAX   = 255;  // hr_input ceiling (8-bit output)
    localparam int CNT_W    = 4;

    // Heart-rate windows must divide 60 so the bpm scale is an exact integer.
    function automatic bit window_legal(input int w);
        case (w)
            1, 2, 3, 4, 5, 6, 10, 12, 15: window_legal = 1'b1;
            default:                      window_legal = 1'b0;
        endcase
    endfunction

    // Per-frame counter update: a frame restart keeps a same-cycle event for
    // the new frame, otherwise count up and stick at CNT_SAT.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic             ev,
                                                  input logic             restart);
        if (restart)
            cnt_next = {{(CNT_W-1){1'b0}}, ev};
        else if (ev && (cnt != CNT_W'(CNT_SAT)))
            cnt_next = cnt + CNT_W'(1);
        else
            cnt_next = cnt;
    endfunction

endpackage

// File: rtl/pulse_conditioner.sv
// Raw pulse conditioning: 2-FF synchronizer, rising-edge detect and a
// lockout timer that swallows contact bounce after each accepted edge.
module pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_raw,
    output logic o_pulse
);
    localparam int LOCK_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]        r_sync;
    logic              r_prev;
    logic [LOCK_W-1:0] r_lock;
    logic              w_edge;

    assign w_edge  = r_sync[1] & ~r_prev;
    assign o_pulse = i_enable & w_edge & (r_lock == '0);

    // Synchronize the asynchronous input and keep the previous value for edge detect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_prev <= r_sync[1];
        end
    end

    // Lockout: load on an accepted edge, count down to 0, forced clear while paused.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_lock <= '0;
        else if (!i_enable)
            r_lock <= '0;
        else if (o_pulse)
            r_lock <= LOCK_W'(DEBOUNCE_CYCLES);
        else if (r_lock != '0)
            r_lock <= r_lock - LOCK_W'(1);
    end

endmodule

// File: rtl/activity_sampler.sv
// Front-end of the step calculator: turns raw step/beat pulses into one-second
// frames carrying steps_per_second, windowed heart rate and latched stride.
module activity_sampler
    import fitness_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int WINDOW_S        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       step_raw,
    input  logic       beat_raw,
    input  logic [7:0] stride_cfg,
    output logic [7:0] hr_input,
    output logic [2:0] steps_per_second,
    output logic [7:0] stride_length,
    output logic       valid_input,
    output logic       hr_warm
);
    localparam int FRAME_W = $clog2(CLK_HZ);
    localparam int FILL_W  = $clog2(WINDOW_S + 1);
    localparam int HR_MULT = 60 / WINDOW_S;

    generate
        if (!window_legal(WINDOW_S)) begin : g_bad_window
            $error("activity_sampler: WINDOW_S=%0d does not divide 60 evenly", WINDOW_S);
        end
    endgenerate

    logic                           w_step, w_beat, w_frame_end;
    logic [FRAME_W-1:0]             r_frame;
    logic [CNT_W-1:0]               r_steps, r_beats;
    logic [WINDOW_S-1:0][CNT_W-1:0] r_hist, w_hist_next;
    logic [FILL_W-1:0]              r_fill;
    logic [7:0]                     w_sum;
    logic [15:0]                    w_hr_prod;
    logic [7:0]                     w_hr;

    pulse_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_cond (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_raw(step_raw), .o_pulse(w_step)
    );

    pulse_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_beat_cond (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_raw(beat_raw), .o_pulse(w_beat)
    );

    assign w_frame_end = enable && (r_frame == FRAME_W'(CLK_HZ - 1));

    // Frame counter: free-runs while enabled, parked at 0 while paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_frame <= '0;
        else if (!enable || w_frame_end)
            r_frame <= '0;
        else
            r_frame <= r_frame + FRAME_W'(1);
    end

    // Per-frame event counters; a pause discards the partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_steps <= '0;
            r_beats <= '0;
        end else if (!enable) begin
            r_steps <= '0;
            r_beats <= '0;
        end else begin
            r_steps <= cnt_next(r_steps, w_step, w_frame_end);
            r_beats <= cnt_next(r_beats, w_beat, w_frame_end);
        end
    end

    // Post-shift beat history and its sum; unfilled slots are zero so the sum
    // naturally covers only the populated entries.
    always_comb begin
        w_hist_next[0] = r_beats;
        for (int i = 1; i < WINDOW_S; i++)
            w_hist_next[i] = r_hist[i-1];
        w_sum = '0;
        for (int i = 0; i < WINDOW_S; i++)
            w_sum = w_sum + 8'(w_hist_next[i]);
    end

    assign w_hr_prod = 16'(w_sum) * 16'(HR_MULT);
    assign w_hr      = (w_hr_prod > 16'(HR_MAX)) ? 8'(HR_MAX) : w_hr_prod[7:0];
    assign hr_warm   = (r_fill == FILL_W'(WINDOW_S));

    // Beat history shifts once per frame; fill tracks how many slots are real.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_frame_end) begin
            r_hist <= w_hist_next;
            if (r_fill != FILL_W'(WINDOW_S))
                r_fill <= r_fill + FILL_W'(1);
        end
    end

    // Frame outputs update the cycle after frame end and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_input      <= 1'b0;
            steps_per_second <= '0;
            stride_length    <= '0;
            hr_input         <= '0;
        end else begin
            valid_input <= w_frame_end;
            if (w_frame_end) begin
                steps_per_second <= (r_steps > CNT_W'(STEP_SAT)) ? 3'(STEP_SAT) : r_steps[2:0];
                stride_length    <= stride_cfg;
                hr_input         <= w_hr;
            end
        end
    end

endmodule

// File: tb/tb_activity_sampler.sv
// Scoreboard bench for activity_sampler: a small frame model pushes expected
// frame results; monitors pop and compare on every valid_input strobe.
module tb_activity_sampler;

    localparam int CLK_HZ = 20;
    localparam int DEB    = 3;
    localparam int WIN    = 6;
    localparam int S_HZ   = 64;   // second instance: room for saturating counts
    localparam int S_DEB  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1, step_raw = 1'b0, beat_raw = 1'b0;
    logic [7:0] stride_cfg = 8'd0;
    logic [7:0] hr_input, stride_length;
    logic [2:0] steps_per_second;
    logic       valid_input, hr_warm;

    logic       s_en = 1'b0, s_step = 1'b0, s_beat = 1'b0;
    logic [7:0] s_stride = 8'd200;
    logic [7:0] s_hr, s_stride_len;
    logic [2:0] s_sps;
    logic       s_valid, s_warm;

    typedef struct { int steps; int stride; int hr; int warm; int cyc; } exp_t;
    exp_t q_main[$], q_sat[$];
    exp_t em, es;
    int   hist[$], s_hist[$];
    int   checks = 0, failures = 0, cyc = 0, last_hr = 0;

    activity_sampler #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .WINDOW_S(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .step_raw(step_raw), .beat_raw(beat_raw),
        .stride_cfg(stride_cfg), .hr_input(hr_input), .steps_per_second(steps_per_second),
        .stride_length(stride_length), .valid_input(valid_input), .hr_warm(hr_warm)
    );

    activity_sampler #(.CLK_HZ(S_HZ), .DEBOUNCE_CYCLES(S_DEB), .WINDOW_S(WIN)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(s_en), .step_raw(s_step), .beat_raw(s_beat),
        .stride_cfg(s_stride), .hr_input(s_hr), .steps_per_second(s_sps),
        .stride_length(s_stride_len), .valid_input(s_valid), .hr_warm(s_warm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: newest beat count at the front, window of WIN frames, bpm = sum*60/WIN.
    task automatic push_exp(input bit sat, input int steps, input int beats, input int stride);
        exp_t e;
        int   sum = 0;
        if (sat) begin
            s_hist.push_front(beats);
            if (s_hist.size() > WIN) void'(s_hist.pop_back());
            foreach (s_hist[k]) sum += s_hist[k];
            e.warm = (s_hist.size() == WIN);
            e.cyc  = cyc + S_HZ;
        end else begin
            hist.push_front(beats);
            if (hist.size() > WIN) void'(hist.pop_back());
            foreach (hist[k]) sum += hist[k];
            e.warm = (hist.size() == WIN);
            e.cyc  = cyc + CLK_HZ;
        end
        e.steps  = (steps > 7) ? 7 : steps;
        e.stride = stride;
        e.hr     = (sum * (60 / WIN) > 255) ? 255 : sum * (60 / WIN);
        if (sat) q_sat.push_back(e);
        else begin
            q_main.push_back(e);
            last_hr = e.hr;
        end
    endtask

    function automatic logic [CLK_HZ-1:0] pulses(input int first, input int spacing, input int n);
        logic [CLK_HZ-1:0] p = '0;
        for (int k = 0; k < n; k++) p = p | (CLK_HZ'(1) << (first + k * spacing));
        return p;
    endfunction

    // One full main frame, entered in the counter-0 cycle (posedge + 1).
    task automatic run_frame(input logic [CLK_HZ-1:0] sp, input logic [CLK_HZ-1:0] bp,
                             input int stride, input int exp_steps, input int exp_beats);
        logic [CLK_HZ-1:0] s = sp, b = bp;
        stride_cfg = 8'(stride);
        push_exp(1'b0, exp_steps, exp_beats, stride);
        for (int i = 0; i < CLK_HZ; i++) begin
            step_raw = s[0];
            beat_raw = b[0];
            s = s >> 1;
            b = b >> 1;
            @(posedge clk); #1;
        end
        step_raw = 1'b0;
        beat_raw = 1'b0;
    endtask

    // Main monitor: every strobe must match the next expected frame.
    always @(negedge clk) begin
        if (valid_input) begin
            checks++;
            if (q_main.size() == 0) begin
                failures++;
                $display("FAIL main_unexpected_strobe cyc=%0d got strobe want none", cyc);
            end else begin
                em = q_main.pop_front();
                checks++;
                if (cyc !== em.cyc) begin failures++; $display("FAIL main_strobe_time got=%0d want=%0d", cyc, em.cyc); end
                checks++;
                if (int'(steps_per_second) !== em.steps) begin failures++; $display("FAIL main_steps got=%0d want=%0d", steps_per_second, em.steps); end
                checks++;
                if (int'(stride_length) !== em.stride) begin failures++; $display("FAIL main_stride got=%0d want=%0d", stride_length, em.stride); end
                checks++;
                if (int'(hr_input) !== em.hr) begin failures++; $display("FAIL main_hr got=%0d want=%0d cyc=%0d", hr_input, em.hr, cyc); end
                checks++;
                if (int'(hr_warm) !== em.warm) begin failures++; $display("FAIL main_warm got=%0d want=%0d cyc=%0d", hr_warm, em.warm, cyc); end
            end
        end
    end

    // Saturation-instance monitor.
    always @(negedge clk) begin
        if (s_valid) begin
            checks++;
            if (q_sat.size() == 0) begin
                failures++;
                $display("FAIL sat_unexpected_strobe cyc=%0d got strobe want none", cyc);
            end else begin
                es = q_sat.pop_front();
                checks++;
                if (cyc !== es.cyc) begin failures++; $display("FAIL sat_strobe_time got=%0d want=%0d", cyc, es.cyc); end
                checks++;
                if (int'(s_sps) !== es.steps) begin failures++; $display("FAIL sat_steps got=%0d want=%0d", s_sps, es.steps); end
                checks++;
                if (int'(s_stride_len) !== es.stride) begin failures++; $display("FAIL sat_stride got=%0d want=%0d", s_stride_len, es.stride); end
                checks++;
                if (int'(s_hr) !== es.hr) begin failures++; $display("FAIL sat_hr got=%0d want=%0d", s_hr, es.hr); end
                checks++;
                if (int'(s_warm) !== es.warm) begin failures++; $display("FAIL sat_warm got=%0d want=%0d", s_warm, es.warm); end
            end
        end
    end

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (hr_input !== 8'd0)         begin failures++; $display("FAIL reset_hr got=%0d want=0", hr_input); end
        checks++; if (steps_per_second !== 3'd0) begin failures++; $display("FAIL reset_steps got=%0d want=0", steps_per_second); end
        checks++; if (stride_length !== 8'd0)    begin failures++; $display("FAIL reset_stride got=%0d want=0", stride_length); end
        checks++; if (valid_input !== 1'b0)      begin failures++; $display("FAIL reset_valid got=%0d want=0", valid_input); end
        checks++; if (hr_warm !== 1'b0)          begin failures++; $display("FAIL reset_warm got=%0d want=0", hr_warm); end
        rst_n = 1'b1;   // this cycle is the first enabled cycle
    endtask

    task automatic test_idle_frames;
        for (int f = 0; f < 6; f++) run_frame('0, '0, 0, 0, 0);
    endtask

    task automatic test_steps;
        for (int f = 0; f < 2; f++) run_frame(pulses(0, 4, 5), '0, 75, 5, 0);
    endtask

    task automatic test_lockout;
        run_frame(pulses(0, 2, 9), '0, 75, 5, 0);             // every other edge lands in lockout
        run_frame(pulses(2, 2, 2), '0, 75, 1, 0);             // high-low-high bounce counts once
    endtask

    task automatic test_hr_ramp;
        for (int f = 0; f < 6; f++) run_frame('0, pulses(0, 8, 2), 75, 0, 2);
    endtask

    task automatic test_frame_edge_beat;
        run_frame('0, pulses(17, 1, 1), 75, 0, 0);            // accepted on the frame-end cycle
        run_frame('0, '0, 75, 0, 1);                          // ...so it shows up here
    endtask

    task automatic test_saturation;
        enable = 1'b0;
        s_en   = 1'b1;
        for (int f = 0; f < 2; f++) begin
            push_exp(1'b1, 15, 15, 200);
            for (int i = 0; i < S_HZ; i++) begin
                s_step = (i <= 40) && (i % 2 == 0);
                s_beat = (i <= 40) && (i % 2 == 0);
                @(posedge clk); #1;
            end
            s_step = 1'b0;
            s_beat = 1'b0;
        end
        s_en   = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_pause;
        logic [CLK_HZ-1:0] s = pulses(0, 4, 2);
        for (int i = 0; i < 10; i++) begin
            step_raw = s[0];
            s = s >> 1;
            @(posedge clk); #1;
        end
        step_raw = 1'b0;
        enable   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            checks++;
            if (valid_input !== 1'b0) begin failures++; $display("FAIL pause_no_strobe got=%0d want=0", valid_input); end
        end
        checks++;
        if (int'(hr_input) !== last_hr) begin failures++; $display("FAIL pause_hr_hold got=%0d want=%0d", hr_input, last_hr); end
        checks++;
        if (stride_length !== 8'd75) begin failures++; $display("FAIL pause_stride_hold got=%0d want=75", stride_length); end
        enable = 1'b1;
        run_frame('0, '0, 75, 0, 0);                          // partial-frame steps discarded
    endtask

    task automatic test_mid_reset;
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (hr_input !== 8'd0)         begin failures++; $display("FAIL midrst_hr got=%0d want=0", hr_input); end
        checks++; if (steps_per_second !== 3'd0) begin failures++; $display("FAIL midrst_steps got=%0d want=0", steps_per_second); end
        checks++; if (stride_length !== 8'd0)    begin failures++; $display("FAIL midrst_stride got=%0d want=0", stride_length); end
        checks++; if (valid_input !== 1'b0)      begin failures++; $display("FAIL midrst_valid got=%0d want=0", valid_input); end
        checks++; if (hr_warm !== 1'b0)          begin failures++; $display("FAIL midrst_warm got=%0d want=0", hr_warm); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hist.delete();
        run_frame('0, pulses(0, 8, 2), 75, 0, 2);
    endtask

    initial begin
        test_reset;
        test_idle_frames;
        test_steps;
        test_lockout;
        test_hr_ramp;
        test_frame_edge_beat;
        test_saturation;
        test_pause;
        test_mid_reset;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q_main.size() != 0) begin failures++; $display("FAIL main_missing_strobes got=%0d pending want=0", q_main.size()); end
        checks++;
        if (q_sat.size() != 0) begin failures++; $display("FAIL sat_missing_strobes got=%0d pending want=0", q_sat.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
